// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types, defaults and index/tag helpers for the tournament branch predictor.
`ifndef XLEN
`define XLEN 32
`endif

package bp_pkg;

    localparam int XLEN                   = `XLEN;
    localparam int INDEX_BITS_DEFAULT     = 8;
    localparam int CTR_BITS_DEFAULT       = 2;
    localparam int HIST_BITS_DEFAULT      = 8;
    localparam int BTB_INDEX_BITS_DEFAULT = 4;

    // Tags are kept zero-extended to XLEN-2 bits so any BTB_INDEX_BITS fits the same entry type.
    localparam int BTB_TAG_BITS = XLEN - 2;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [XLEN-1:0]         target_pc;
    } btb_entry_t;

    function automatic logic [XLEN-1:0] idx(input logic [XLEN-1:0] pc, input int indexBits);
        return (pc >> 2) & ((XLEN'(1) << indexBits) - XLEN'(1));
    endfunction

    function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [XLEN-1:0] pc, input int btbIndexBits);
        return BTB_TAG_BITS'(pc >> (btbIndexBits + 2));
    endfunction

endpackage

// File: rtl/tournament_branch_predictor_counter_table.sv
// Table of saturating counters with a fetch read port, an ex read port and one update port.
module bp_counter_table #(
    parameter int                  INDEX_BITS = 8,
    parameter int                  CTR_BITS   = 2,
    parameter logic [CTR_BITS-1:0] RESET_VAL  = {1'b1, {(CTR_BITS-1){1'b0}}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] i_fetchIdx,
    output logic [CTR_BITS-1:0]   o_fetchCtr,
    input  logic [INDEX_BITS-1:0] i_exIdx,
    output logic [CTR_BITS-1:0]   o_exCtr,
    input  logic                  i_updEn,
    input  logic [INDEX_BITS-1:0] i_updIdx,
    input  logic                  i_updInc
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0] r_ctr [ENTRIES];

    assign o_fetchCtr = r_ctr[i_fetchIdx];
    assign o_exCtr    = r_ctr[i_exIdx];

    // Counters saturate at both ends instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= RESET_VAL;
            end
        end else if (i_updEn) begin
            if (i_updInc) begin
                if (r_ctr[i_updIdx] != '1) begin
                    r_ctr[i_updIdx] <= r_ctr[i_updIdx] + CTR_BITS'(1);
                end
            end else if (r_ctr[i_updIdx] != '0) begin
                r_ctr[i_updIdx] <= r_ctr[i_updIdx] - CTR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament (bimodal + gshare + selector) predictor with tagged BTB, speculative history
// with per-prediction snapshots, and branch/mispredict performance counters.
module tournament_branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS     = INDEX_BITS_DEFAULT,
    parameter int CTR_BITS       = CTR_BITS_DEFAULT,
    parameter int HIST_BITS      = HIST_BITS_DEFAULT,
    parameter int BTB_INDEX_BITS = BTB_INDEX_BITS_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_if_valid,
    input  logic [XLEN-1:0]      i_if_pc,
    output logic                 o_predict_taken,
    output logic [XLEN-1:0]      o_predict_target_pc,
    output logic [HIST_BITS-1:0] o_predict_hist,
    input  logic                 i_ex_branch,
    input  logic [XLEN-1:0]      i_ex_pc,
    input  logic                 i_ex_taken,
    input  logic [XLEN-1:0]      i_ex_target_pc,
    input  logic [HIST_BITS-1:0] i_ex_hist,
    input  logic                 i_ex_mispredict,
    output logic [31:0]          o_perf_branches,
    output logic [31:0]          o_perf_mispredicts
);

    localparam int                  BTB_ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int                  MSB         = CTR_BITS - 1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK    = {1'b1, {(CTR_BITS-1){1'b0}}};

    logic [INDEX_BITS-1:0]     w_fetchIdx;
    logic [INDEX_BITS-1:0]     w_fetchGshareIdx;
    logic [INDEX_BITS-1:0]     w_exIdx;
    logic [INDEX_BITS-1:0]     w_exGshareIdx;
    logic [BTB_INDEX_BITS-1:0] w_fetchBtbIdx;
    logic [BTB_INDEX_BITS-1:0] w_exBtbIdx;
    logic [CTR_BITS-1:0]       w_bimodFetchCtr;
    logic [CTR_BITS-1:0]       w_gshareFetchCtr;
    logic [CTR_BITS-1:0]       w_selFetchCtr;
    logic [CTR_BITS-1:0]       w_bimodExCtr;
    logic [CTR_BITS-1:0]       w_gshareExCtr;
    logic [CTR_BITS-1:0]       w_unusedSelExCtr;
    logic                      w_unusedCtrBits;
    btb_entry_t                w_fetchEntry;
    logic                      w_btbHit;
    logic                      w_fetchDir;
    logic                      w_bimodExDir;
    logic                      w_gshareExDir;
    logic                      w_selUpdEn;
    logic                      w_selUpdInc;

    logic [HIST_BITS-1:0]      r_specHist;
    btb_entry_t                r_btb [BTB_ENTRIES];
    logic [31:0]               r_perfBranches;
    logic [31:0]               r_perfMispredicts;

    assign w_fetchIdx       = INDEX_BITS'(idx(i_if_pc, INDEX_BITS));
    assign w_fetchGshareIdx = w_fetchIdx ^ INDEX_BITS'(r_specHist);
    assign w_exIdx          = INDEX_BITS'(idx(i_ex_pc, INDEX_BITS));
    assign w_exGshareIdx    = w_exIdx ^ INDEX_BITS'(i_ex_hist);
    assign w_fetchBtbIdx    = BTB_INDEX_BITS'(i_if_pc >> 2);
    assign w_exBtbIdx       = BTB_INDEX_BITS'(i_ex_pc >> 2);

    assign w_fetchEntry = r_btb[w_fetchBtbIdx];
    assign w_btbHit     = w_fetchEntry.valid && (w_fetchEntry.tag == btb_tag(i_if_pc, BTB_INDEX_BITS));
    assign w_fetchDir   = w_selFetchCtr[MSB] ? w_bimodFetchCtr[MSB] : w_gshareFetchCtr[MSB];

    assign o_predict_taken     = w_fetchDir && w_btbHit;
    assign o_predict_target_pc = w_fetchEntry.target_pc;
    assign o_predict_hist      = r_specHist;
    assign o_perf_branches     = r_perfBranches;
    assign o_perf_mispredicts  = r_perfMispredicts;

    // The selector only learns when the two predictors disagreed, moving toward whichever was right.
    assign w_bimodExDir  = w_bimodExCtr[MSB];
    assign w_gshareExDir = w_gshareExCtr[MSB];
    assign w_selUpdEn    = i_ex_branch && (w_bimodExDir != w_gshareExDir);
    assign w_selUpdInc   = (w_bimodExDir == i_ex_taken);

    assign w_unusedCtrBits = ^{w_selFetchCtr, w_bimodFetchCtr, w_gshareFetchCtr, w_bimodExCtr, w_gshareExCtr};

    bp_counter_table #(.INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS), .RESET_VAL(CTR_WEAK)) u_bimod (
        .clock      (clock),
        .reset      (reset),
        .i_fetchIdx (w_fetchIdx),
        .o_fetchCtr (w_bimodFetchCtr),
        .i_exIdx    (w_exIdx),
        .o_exCtr    (w_bimodExCtr),
        .i_updEn    (i_ex_branch),
        .i_updIdx   (w_exIdx),
        .i_updInc   (i_ex_taken)
    );

    bp_counter_table #(.INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS), .RESET_VAL(CTR_WEAK)) u_gshare (
        .clock      (clock),
        .reset      (reset),
        .i_fetchIdx (w_fetchGshareIdx),
        .o_fetchCtr (w_gshareFetchCtr),
        .i_exIdx    (w_exGshareIdx),
        .o_exCtr    (w_gshareExCtr),
        .i_updEn    (i_ex_branch),
        .i_updIdx   (w_exGshareIdx),
        .i_updInc   (i_ex_taken)
    );

    bp_counter_table #(.INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS), .RESET_VAL(CTR_WEAK)) u_selector (
        .clock      (clock),
        .reset      (reset),
        .i_fetchIdx (w_fetchIdx),
        .o_fetchCtr (w_selFetchCtr),
        .i_exIdx    (w_exIdx),
        .o_exCtr    (w_unusedSelExCtr),
        .i_updEn    (w_selUpdEn),
        .i_updIdx   (w_exIdx),
        .i_updInc   (w_selUpdInc)
    );

    // Only taken branches allocate; a not-taken result keeps the existing target.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else if (i_ex_branch && i_ex_taken) begin
            r_btb[w_exBtbIdx] <= '{valid: 1'b1,
                                   tag: btb_tag(i_ex_pc, BTB_INDEX_BITS),
                                   target_pc: i_ex_target_pc};
        end
    end

    // Repair from the returned snapshot takes priority over a same-cycle speculative shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_specHist <= '1;
        end else if (i_ex_branch && i_ex_mispredict) begin
            r_specHist <= HIST_BITS'({i_ex_taken, i_ex_hist} >> 1);
        end else if (i_if_valid && w_btbHit) begin
            r_specHist <= HIST_BITS'({w_fetchDir, r_specHist} >> 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perfBranches    <= '0;
            r_perfMispredicts <= '0;
        end else if (i_ex_branch) begin
            r_perfBranches <= r_perfBranches + 32'd1;
            if (i_ex_mispredict) begin
                r_perfMispredicts <= r_perfMispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed and randomized checks of tournament_branch_predictor against a behavioural model.
module tb_tournament_branch_predictor;

    localparam int TABLE_SIZE = 256;
    localparam int BTB_SIZE   = 16;
    localparam int CTR_MAX    = 3;
    localparam int WEAK       = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifValid;
    logic [31:0] ifPc;
    logic        predictTaken;
    logic [31:0] predictTarget;
    logic [7:0]  predictHist;
    logic        exBranch;
    logic [31:0] exPc;
    logic        exTaken;
    logic [31:0] exTarget;
    logic [7:0]  exHist;
    logic        exMispredict;
    logic [31:0] perfBranches;
    logic [31:0] perfMispredicts;

    int checksTotal  = 0;
    int checksPassed = 0;

    int          mBim [TABLE_SIZE];
    int          mGsh [TABLE_SIZE];
    int          mSel [TABLE_SIZE];
    bit          mBtbValid [BTB_SIZE];
    int unsigned mBtbTag [BTB_SIZE];
    int unsigned mBtbTarget [BTB_SIZE];
    int          mHist;
    int unsigned mBranches;
    int unsigned mMispredicts;

    tournament_branch_predictor dut (
        .clock               (clock),
        .reset               (reset),
        .i_if_valid          (ifValid),
        .i_if_pc             (ifPc),
        .o_predict_taken     (predictTaken),
        .o_predict_target_pc (predictTarget),
        .o_predict_hist      (predictHist),
        .i_ex_branch         (exBranch),
        .i_ex_pc             (exPc),
        .i_ex_taken          (exTaken),
        .i_ex_target_pc      (exTarget),
        .i_ex_hist           (exHist),
        .i_ex_mispredict     (exMispredict),
        .o_perf_branches     (perfBranches),
        .o_perf_mispredicts  (perfMispredicts)
    );

    always #5 clock = ~clock;

    task automatic modelReset();
        for (int i = 0; i < TABLE_SIZE; i++) begin
            mBim[i] = WEAK;
            mGsh[i] = WEAK;
            mSel[i] = WEAK;
        end
        for (int i = 0; i < BTB_SIZE; i++) begin
            mBtbValid[i]  = 1'b0;
            mBtbTag[i]    = 0;
            mBtbTarget[i] = 0;
        end
        mHist        = 255;
        mBranches    = 0;
        mMispredicts = 0;
    endtask

    function automatic int satStep(input int c, input bit up);
        if (up) return (c < CTR_MAX) ? c + 1 : CTR_MAX;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic modelPredict(input logic [31:0] pc, output bit dir, output bit hit, output logic [31:0] target);
        int i;
        int g;
        int b;
        i = int'(pc / 4) % TABLE_SIZE;
        g = i ^ mHist;
        b = int'(pc / 4) % BTB_SIZE;
        dir    = (mSel[i] >= WEAK) ? (mBim[i] >= WEAK) : (mGsh[g] >= WEAK);
        hit    = mBtbValid[b] && (mBtbTag[b] == pc / 64);
        target = mBtbTarget[b];
    endtask

    // Applies one clock edge of architectural behaviour using the inputs the DUT sampled.
    task automatic modelClock();
        bit          fDir;
        bit          fHit;
        logic [31:0] fTarget;
        int          i;
        int          g;
        int          b;
        bit          bimRight;
        bit          gshRight;
        if (reset) begin
            modelReset();
        end else begin
            modelPredict(ifPc, fDir, fHit, fTarget);
            if (exBranch) begin
                i = int'(exPc / 4) % TABLE_SIZE;
                g = i ^ int'(exHist);
                b = int'(exPc / 4) % BTB_SIZE;
                bimRight = ((mBim[i] >= WEAK) == exTaken);
                gshRight = ((mGsh[g] >= WEAK) == exTaken);
                if (bimRight != gshRight) mSel[i] = satStep(mSel[i], bimRight);
                mBim[i] = satStep(mBim[i], exTaken);
                mGsh[g] = satStep(mGsh[g], exTaken);
                if (exTaken) begin
                    mBtbValid[b]  = 1'b1;
                    mBtbTag[b]    = exPc / 64;
                    mBtbTarget[b] = exTarget;
                end
                mBranches++;
                if (exMispredict) mMispredicts++;
            end
            if (exBranch && exMispredict) mHist = int'(exTaken) * 128 + int'(exHist) / 2;
            else if (ifValid && fHit) mHist = int'(fDir) * 128 + mHist / 2;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelClock();
        #1;
    endtask

    task automatic applyStimulus(input bit fv, input logic [31:0] fpc, input bit eb, input logic [31:0] epc,
                                 input bit et, input logic [31:0] etgt, input logic [7:0] eh, input bit em);
        ifValid      = fv;
        ifPc         = fpc;
        exBranch     = eb;
        exPc         = epc;
        exTaken      = et;
        exTarget     = etgt;
        exHist       = eh;
        exMispredict = em;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic checkAgainstModel(input string tag);
        bit          dir;
        bit          hit;
        logic [31:0] target;
        modelPredict(ifPc, dir, hit, target);
        checkOutput({tag, "_taken"}, 32'(predictTaken), 32'(dir && hit));
        checkOutput({tag, "_target"}, predictTarget, target);
        checkOutput({tag, "_hist"}, 32'(predictHist), 32'(mHist));
        checkOutput({tag, "_branches"}, perfBranches, mBranches);
        checkOutput({tag, "_mispredicts"}, perfMispredicts, mMispredicts);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0]  rHist;
        logic [31:0] rPc;
        modelReset();
        doReset();

        $display("[TB] reset state");
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("rst_taken", 32'(predictTaken), 32'h0);
        checkOutput("rst_target", predictTarget, 32'h0);
        checkOutput("rst_hist", 32'(predictHist), 32'hFF);
        checkOutput("rst_branches", perfBranches, 32'h0);
        checkOutput("rst_mispredicts", perfMispredicts, 32'h0);

        $display("[TB] first taken branch allocates BTB");
        applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 8'hFF, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("alloc_taken", 32'(predictTaken), 32'h1);
        checkOutput("alloc_target", predictTarget, 32'h200);
        checkOutput("alloc_branches", perfBranches, 32'h1);

        $display("[TB] not-taken training saturates at zero");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 8'hFF, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("nt4_taken", 32'(predictTaken), 32'h0);
        checkOutput("nt4_target", predictTarget, 32'h200);
        applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 8'hFF, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("nt5_taken", 32'(predictTaken), 32'h0);
        checkOutput("nt5_branches", perfBranches, 32'd6);

        $display("[TB] speculative history shift and repair");
        applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("spec0_hist", 32'(predictHist), 32'hFF);
        tick();
        checkOutput("spec1_hist", 32'(predictHist), 32'h7F);
        tick();
        checkOutput("spec2_hist", 32'(predictHist), 32'h3F);
        applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 8'h7F, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("repair_hist", 32'(predictHist), 32'hBF);
        checkOutput("repair_mispredicts", perfMispredicts, 32'h1);

        $display("[TB] repair wins over same-cycle fetch shift");
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("conflict_hist", 32'(predictHist), 32'h00);
        checkOutput("conflict_mispredicts", perfMispredicts, 32'h2);
        checkAgainstModel("conflict");

        $display("[TB] selector training on disagreement");
        doReset();
        applyStimulus(1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h400, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 32'h0, 8'hFF, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("sel_agree_taken", 32'(predictTaken), 32'h1);
        applyStimulus(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 32'h0, 8'hFF, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("sel_dis_taken", 32'(predictTaken), 32'h0);
        applyStimulus(1'b0, 32'h300, 1'b1, 32'h004, 1'b0, 32'h0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("sel_gshare_hist", 32'(predictHist), 32'h00);
        checkOutput("sel_gshare_taken", 32'(predictTaken), 32'h1);
        checkAgainstModel("sel");

        $display("[TB] reset mid-operation discards same-cycle updates");
        reset = 1'b1;
        applyStimulus(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h500, 8'h12, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        checkOutput("midrst_taken", 32'(predictTaken), 32'h0);
        checkOutput("midrst_target", predictTarget, 32'h0);
        checkOutput("midrst_hist", 32'(predictHist), 32'hFF);
        checkOutput("midrst_branches", perfBranches, 32'h0);

        $display("[TB] randomized traffic against reference model");
        for (int n = 0; n < 600; n++) begin
            rHist = ($urandom_range(0, 1) == 0) ? 8'(mHist) : 8'($urandom_range(0, 255));
            rPc   = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2));
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus(1'($urandom_range(0, 1)), rPc,
                          1'($urandom_range(0, 1)),
                          32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2)),
                          1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023) << 2), rHist,
                          ($urandom_range(0, 3) == 0));
            checkAgainstModel("rand");
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
